data_memory_bytelane: RTL and testbench
=======================================

Name: data_memory_bytelane

Overview:
- Parametrised successor to the word-only data memory in the MEM stage of the MIPS pipeline.
- Supports byte, halfword and word loads and stores, with per-lane write enables and sign or zero extension on loads.
- Read data is registered with one-cycle latency, so the pipeline samples it at the MEM/WB boundary.
- Detects misaligned and out-of-range accesses, suppresses them, and records the first faulting address in a sticky register.

Parameters:
ADDR_WIDTH, 32, width of the byte address input.
DEPTH_WORDS, 2048, number of 32-bit words in the array; must be a power of two, at least 2.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4 aligned.
WORD_IDX_W, log2(DEPTH_WORDS), derived; not to be overridden.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset.
MemRead  in  1  load request this cycle.
MemWrite  in  1  store request this cycle.
Size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
SignExt  in  1  loads only: 1 sign-extends, 0 zero-extends.
Address  in  ADDR_WIDTH  byte address.
Write_data  in  32  store data, right-justified; the low byte or half is used for sub-word stores.
readData  out  32  registered, extended load result.
rd_valid  out  1  readData is valid this cycle.
fault  out  1  one-cycle pulse, aligned with rd_valid timing, for a rejected access.
fault_code  out  2  01 misaligned, 10 out of range, 11 both; 00 when fault is 0.
fault_sticky  out  1  set on first fault; held until reset.
fault_addr  out  ADDR_WIDTH  Address of the first fault; frozen while fault_sticky is 1.

Behaviour:
- Reset (reset=0, async):
  - readData=0, rd_valid=0, fault=0, fault_code=0, fault_sticky=0, fault_addr=0.
  - Array contents are not cleared.
  - Reset asserted mid-access aborts that access: no write, no rd_valid.
- Offset and word index:
  - off = Address - BASE_ADDR.
  - Out of range if off >= DEPTH_WORDS*4, including underflow wrap.
  - Word index = off[WORD_IDX_W+1:2]; lane = off[1:0].
- Misaligned:
  - Halfword with lane[0]=1.
  - Word with lane!=0.
  - Size=11, in any case.
- Access = MemRead | MemWrite. A faulting access performs no array write.
- Store, cycle N, non-faulting, array written at edge N:
  - Byte: write enable = 1<<lane; data = Write_data[7:0] replicated to all lanes.
  - Half: write enable = 0011 << lane; data = Write_data[15:0] replicated.
  - Word: all four enables; data = Write_data.
  - Lane 0 = bits 7:0 (little-endian within the word).
- Load, cycle N: rd_valid=1 in cycle N+1, with readData set as follows:
  - Non-faulting: the selected byte or half shifted to bit 0 and extended per SignExt; for a word, the whole word.
  - Faulting: readData=0.
  - rd_valid=0 cycles: readData holds 0.
- Simultaneous MemRead and MemWrite, same cycle:
  - Write-first: the load returns the word after the store merge.
  - Example: word 0x11223344, store byte 0xAA at lane 1, load word → 0x1122AA44.
- Back-to-back:
  - Store at N, load of the same word at N+1 returns the new data; no stall.
  - Loads every cycle give rd_valid every cycle (fully pipelined, throughput 1).
- Fault reporting:
  - fault and fault_code are registered and asserted in cycle N+1 for any faulting access, load or store.
  - When fault_sticky=0, fault_addr<=Address and fault_sticky<=1 at the same edge. Later faults do not update them.
- No access (MemRead=MemWrite=0): array unchanged; rd_valid=0 and fault=0 next cycle.
- SignExt and Size are ignored for pure stores, except that Size drives alignment checks and lane selection.

Test Plan:
- Reset, then store word 0xDEADBEEF at BASE+0x10; load word BASE+0x10 next cycle → readData=0xDEADBEEF, rd_valid=1 exactly one cycle after the load.
- Store byte 0x80 at BASE+0x11 over word 0 → signed byte load = 0xFFFFFF80; unsigned = 0x00000080; word load = 0xDEAD80EF.
- Halfword load at BASE+0x12 with SignExt=1 on word 0xDEAD80EF → 0xFFFFDEAD.
- Store word at BASE+0x6:
  - Required response: fault=1 and fault_code=01 next cycle; array unchanged; fault_sticky=1; fault_addr=BASE+0x6.
  - Then load at BASE+DEPTH_WORDS*4 → fault_code=10; fault_addr still BASE+0x6.
- Simultaneous store half 0x1234 at lane 2 and word load of the same word holding 0x11223344 → 0x12343344.
- Assert reset low mid-stream with a load pending → rd_valid, readData and the fault outputs are 0 immediately. After release, memory still holds 0xDEAD80EF at BASE+0x10.

Source files
------------

// File: rtl/data_memory_bytelane_if.sv
// Load/store bus between the MEM stage and the byte-lane data memory.
// The master drives requests; the slave returns registered load data and faults.
interface data_memory_bytelane_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  MemRead;
    logic                  MemWrite;
    logic [1:0]            Size;
    logic                  SignExt;
    logic [ADDR_WIDTH-1:0] Address;
    logic [31:0]           Write_data;
    logic [31:0]           readData;
    logic                  rd_valid;
    logic                  fault;
    logic [1:0]            fault_code;
    logic                  fault_sticky;
    logic [ADDR_WIDTH-1:0] fault_addr;

    modport master (
        output MemRead,
        output MemWrite,
        output Size,
        output SignExt,
        output Address,
        output Write_data,
        input  readData,
        input  rd_valid,
        input  fault,
        input  fault_code,
        input  fault_sticky,
        input  fault_addr
    );

    modport slave (
        input  MemRead,
        input  MemWrite,
        input  Size,
        input  SignExt,
        input  Address,
        input  Write_data,
        output readData,
        output rd_valid,
        output fault,
        output fault_code,
        output fault_sticky,
        output fault_addr
    );
endinterface

// File: rtl/data_memory_bytelane.sv
// Byte-lane data memory: byte/half/word loads and stores, registered reads,
// misalignment and range checking with a sticky first-fault address.
module data_memory_bytelane #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 2048,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    localparam int                   WORD_IDX_W  = $clog2(DEPTH_WORDS)
) (
    input logic                   clk,
    input logic                   reset,
    data_memory_bytelane_if.slave bus
);
    localparam int OFF_W = WORD_IDX_W + 2;

    logic [31:0] mem [DEPTH_WORDS];

    logic [ADDR_WIDTH-1:0] off;
    logic [WORD_IDX_W-1:0] idx;
    logic [1:0]            lane;
    logic                  oor;
    logic                  mis;
    logic                  is_b;
    logic                  is_h;
    logic                  is_w;
    logic                  access;
    logic                  bad;
    logic                  wr_en;
    logic                  rd_en;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [31:0]           old_word;
    logic [31:0]           merged;
    logic [31:0]           shifted;
    logic [31:0]           load_val;
    logic [31:0]           rdata_d;

    assign off  = bus.Address - BASE_ADDR;
    assign idx  = off[OFF_W-1:2];
    assign lane = off[1:0];

    // Power-of-two depth: anything above the in-range span, including wrap, is out of range
    generate
        if (ADDR_WIDTH > OFF_W) begin : g_oor
            assign oor = |off[ADDR_WIDTH-1:OFF_W];
        end else begin : g_no_oor
            assign oor = 1'b0;
        end
    endgenerate

    assign is_b = (bus.Size == 2'b00);
    assign is_h = (bus.Size == 2'b01);
    assign is_w = (bus.Size == 2'b10);

    always_comb begin
        mis   = 1'b1;
        be    = 4'b0000;
        wdata = bus.Write_data;
        unique case (1'b1)
            is_b: begin
                mis   = 1'b0;
                be    = 4'b0001 << lane;
                wdata = {4{bus.Write_data[7:0]}};
            end
            is_h: begin
                mis   = lane[0];
                be    = 4'b0011 << lane;
                wdata = {2{bus.Write_data[15:0]}};
            end
            is_w: begin
                mis   = |lane;
                be    = 4'b1111;
                wdata = bus.Write_data;
            end
            default: begin
                mis   = 1'b1;
                be    = 4'b0000;
                wdata = bus.Write_data;
            end
        endcase
    end

    assign access = bus.MemRead | bus.MemWrite;
    assign bad    = mis | oor;
    assign wr_en  = bus.MemWrite & ~bad;
    assign rd_en  = bus.MemRead & ~bad;

    assign old_word = mem[idx];

    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wr_en && be[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    assign shifted = merged >> {lane, 3'b000};

    // A combined read+write returns the whole merged word, write-first
    always_comb begin
        load_val = merged;
        if (!bus.MemWrite) begin
            unique case (1'b1)
                is_b: load_val = bus.SignExt
                    ? {{24{shifted[7]}}, shifted[7:0]}
                    : {24'h0, shifted[7:0]};
                is_h: load_val = bus.SignExt
                    ? {{16{shifted[15]}}, shifted[15:0]}
                    : {16'h0, shifted[15:0]};
                default: load_val = merged;
            endcase
        end
    end

    assign rdata_d = rd_en ? load_val : 32'h0;

    // Reset low aborts a store on the same edge
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem[idx] <= merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.readData     <= 32'h0;
            bus.rd_valid     <= 1'b0;
            bus.fault        <= 1'b0;
            bus.fault_code   <= 2'b00;
            bus.fault_sticky <= 1'b0;
            bus.fault_addr   <= '0;
        end else begin
            bus.readData   <= rdata_d;
            bus.rd_valid   <= bus.MemRead;
            bus.fault      <= access & bad;
            bus.fault_code <= access ? {oor, mis} : 2'b00;
            if (access && bad && !bus.fault_sticky) begin
                bus.fault_sticky <= 1'b1;
                bus.fault_addr   <= bus.Address;
            end
        end
    end
endmodule

// File: tb/tb_data_memory_bytelane.sv
// Directed bench for data_memory_bytelane: loads, stores, faults, write-first
// merging and asynchronous reset, with immediate assertions at each check.
module tb_data_memory_bytelane;
    localparam int          AW   = 32;
    localparam int          DW   = 2048;
    localparam logic [31:0] B    = 32'h1000_0000;
    localparam logic [31:0] SPAN = DW * 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    data_memory_bytelane_if #(.ADDR_WIDTH(AW)) bus ();

    data_memory_bytelane #(
        .ADDR_WIDTH (AW),
        .DEPTH_WORDS(DW),
        .BASE_ADDR  (B)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a,
                         input logic [31:0] wd);
        bus.MemRead    = r;
        bus.MemWrite   = w;
        bus.Size       = sz;
        bus.SignExt    = sx;
        bus.Address    = a;
        bus.Write_data = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
        #3;
        chk("rst_rdata", bus.readData, 32'h0);
        chk("rst_valid", {31'h0, bus.rd_valid}, 32'h0);
        chk("rst_fault", {31'h0, bus.fault}, 32'h0);
        chk("rst_code", {30'h0, bus.fault_code}, 32'h0);
        chk("rst_sticky", {31'h0, bus.fault_sticky}, 32'h0);
        chk("rst_faddr", bus.fault_addr, 32'h0);
        tick();
        reset = 1'b1;

        drive(0, 1, 2'b10, 0, B + 32'h10, 32'hDEAD_BEEF);
        tick();
        chk("st_w_valid", {31'h0, bus.rd_valid}, 32'h0);
        chk("st_w_fault", {31'h0, bus.fault}, 32'h0);
        drive(1, 0, 2'b10, 0, B + 32'h10, 32'h0);
        tick();
        chk("ld_w_valid", {31'h0, bus.rd_valid}, 32'h1);
        chk("ld_w_data", bus.readData, 32'hDEAD_BEEF);
        drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
        tick();
        chk("idle_valid", {31'h0, bus.rd_valid}, 32'h0);
        chk("idle_data", bus.readData, 32'h0);
        chk("idle_fault", {31'h0, bus.fault}, 32'h0);

        drive(0, 1, 2'b10, 0, B + 32'h4, 32'h5566_7788);
        tick();
        drive(0, 1, 2'b00, 0, B + 32'h11, 32'h1234_5680);
        tick();
        drive(1, 0, 2'b00, 1, B + 32'h11, 32'h0);
        tick();
        chk("ld_b_s", bus.readData, 32'hFFFF_FF80);
        drive(1, 0, 2'b00, 0, B + 32'h11, 32'h0);
        tick();
        chk("ld_b_u", bus.readData, 32'h0000_0080);
        chk("ld_b_u_valid", {31'h0, bus.rd_valid}, 32'h1);
        drive(1, 0, 2'b10, 0, B + 32'h10, 32'h0);
        tick();
        chk("ld_w_merge", bus.readData, 32'hDEAD_80EF);
        drive(1, 0, 2'b01, 1, B + 32'h12, 32'h0);
        tick();
        chk("ld_h_s", bus.readData, 32'hFFFF_DEAD);
        drive(1, 0, 2'b01, 0, B + 32'h10, 32'h0);
        tick();
        chk("ld_h_u", bus.readData, 32'h0000_80EF);

        drive(0, 1, 2'b10, 0, B + 32'h6, 32'hCAFE_F00D);
        tick();
        chk("mis_fault", {31'h0, bus.fault}, 32'h1);
        chk("mis_code", {30'h0, bus.fault_code}, 32'h1);
        chk("mis_sticky", {31'h0, bus.fault_sticky}, 32'h1);
        chk("mis_faddr", bus.fault_addr, B + 32'h6);
        chk("mis_valid", {31'h0, bus.rd_valid}, 32'h0);
        drive(1, 0, 2'b10, 0, B + 32'h4, 32'h0);
        tick();
        chk("mis_unchanged", bus.readData, 32'h5566_7788);
        chk("ok_fault", {31'h0, bus.fault}, 32'h0);
        chk("ok_code", {30'h0, bus.fault_code}, 32'h0);

        drive(1, 0, 2'b10, 0, B + SPAN, 32'h0);
        tick();
        chk("oor_fault", {31'h0, bus.fault}, 32'h1);
        chk("oor_code", {30'h0, bus.fault_code}, 32'h2);
        chk("oor_valid", {31'h0, bus.rd_valid}, 32'h1);
        chk("oor_data", bus.readData, 32'h0);
        chk("oor_faddr", bus.fault_addr, B + 32'h6);
        drive(1, 0, 2'b10, 0, B - 32'h4, 32'h0);
        tick();
        chk("under_code", {30'h0, bus.fault_code}, 32'h2);
        drive(1, 0, 2'b01, 0, B + SPAN + 32'h1, 32'h0);
        tick();
        chk("both_code", {30'h0, bus.fault_code}, 32'h3);
        drive(1, 0, 2'b11, 0, B + 32'h10, 32'h0);
        tick();
        chk("rsv_code", {30'h0, bus.fault_code}, 32'h1);
        chk("rsv_data", bus.readData, 32'h0);

        drive(0, 1, 2'b10, 0, B + 32'h20, 32'h1122_3344);
        tick();
        drive(1, 1, 2'b00, 0, B + 32'h21, 32'h0000_00AA);
        tick();
        chk("rw_byte", bus.readData, 32'h1122_AA44);
        drive(0, 1, 2'b10, 0, B + 32'h20, 32'h1122_3344);
        tick();
        drive(1, 1, 2'b01, 0, B + 32'h22, 32'h0000_1234);
        tick();
        chk("rw_half", bus.readData, 32'h1234_3344);
        drive(1, 0, 2'b10, 0, B + 32'h20, 32'h0);
        tick();
        chk("rw_stored", bus.readData, 32'h1234_3344);

        drive(1, 0, 2'b10, 0, B + 32'h10, 32'h0);
        tick();
        chk("pre_rst_data", bus.readData, 32'hDEAD_80EF);
        drive(1, 1, 2'b10, 0, B + 32'h10, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", {31'h0, bus.rd_valid}, 32'h0);
        chk("arst_data", bus.readData, 32'h0);
        chk("arst_fault", {31'h0, bus.fault}, 32'h0);
        chk("arst_code", {30'h0, bus.fault_code}, 32'h0);
        chk("arst_sticky", {31'h0, bus.fault_sticky}, 32'h0);
        chk("arst_faddr", bus.fault_addr, 32'h0);
        tick();
        drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
        reset = 1'b1;
        drive(1, 0, 2'b10, 0, B + 32'h10, 32'h0);
        tick();
        chk("post_rst_mem", bus.readData, 32'hDEAD_80EF);
        chk("post_rst_valid", {31'h0, bus.rd_valid}, 32'h1);
        drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
